// File: rtl/hp_pkg.sv
// Shared definitions for the FP16 accumulate stage.
//   FP16 field constants, adder exception codes, accumulator FSM encoding.
package hp_pkg;

  localparam int          FP16_W    = 16;
  localparam int          FP16_SIGN = 15;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_UNF  = 2'b10;
  localparam logic [1:0] EXC_INV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_OP = 2'd1,
    ST_ADD     = 2'd2,
    ST_DONE    = 2'd3
  } hp_state_t;

endpackage

// File: rtl/hp_accumulator.sv
// FP16 accumulate stage driving an external combinational FP16 adder.
// Takes len operands over op_valid/op_ready, feeds the running sum to adder
// input A and the (optionally negated) operand to input B, captures the sum,
// and returns the total plus the first exception code on res_valid/res_ready.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, len                  job request (sampled in IDLE only)
//   op_valid/op_ready/op_data   operand stream, op_sub negates the operand
//   add_a, add_b                to adder inputs (running sum, operand)
//   add_sum, add_exc            from adder outputs
//   res_valid/res_ready         result handshake
//   res_data, res_exc           accumulated sum, sticky exception code
//   busy, count                 status: not idle, terms consumed
//
// state   | meaning
// IDLE    | waiting for start
// WAIT_OP | op_ready high, waiting for an operand
// ADD     | adder inputs stable, sum/exception captured at cycle end
// DONE    | result presented until res_ready
module hp_accumulator
  import hp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [15:0]       op_data,
  input  logic              op_sub,
  output logic [15:0]       add_a,
  output logic [15:0]       add_b,
  input  logic [15:0]       add_sum,
  input  logic [1:0]        add_exc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic [1:0]        res_exc,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  hp_state_t          r_state;
  logic [15:0]        r_acc;
  logic [CNT_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   r_count;
  logic [15:0]        r_add_a;
  logic [15:0]        r_add_b;
  logic [15:0]        r_res_data;
  logic [1:0]         r_res_exc;
  logic               r_op_ready;
  logic               r_res_valid;
  logic               r_busy;
  logic               w_last;

  assign w_last = (r_remaining == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= FP16_ZERO;
      r_remaining <= '0;
      r_count     <= '0;
      r_add_a     <= FP16_ZERO;
      r_add_b     <= FP16_ZERO;
      r_res_data  <= FP16_ZERO;
      r_res_exc   <= EXC_NONE;
      r_op_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc       <= FP16_ZERO;
            r_remaining <= len;
            r_res_exc   <= EXC_NONE;
            r_count     <= '0;
            r_busy      <= 1'b1;
            if (len == '0) begin
              r_state     <= ST_DONE;
              r_res_data  <= FP16_ZERO;
              r_res_valid <= 1'b1;
            end else begin
              r_state    <= ST_WAIT_OP;
              r_op_ready <= 1'b1;
            end
          end
        end
        ST_WAIT_OP: begin
          if (op_valid) begin
            r_add_a    <= r_acc;
            r_add_b    <= {op_data[FP16_SIGN] ^ op_sub, op_data[14:0]};
            r_op_ready <= 1'b0;
            r_state    <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_count     <= r_count + CNT_W'(1);
          r_remaining <= r_remaining - CNT_W'(1);
          // Default result is the held sum; overridden below when this add loads.
          if (w_last) r_res_data <= r_acc;
          if (r_res_exc == EXC_NONE) begin
            // A case on add_exc sends X/Z codes to the default arm, so an
            // unknown exception is recorded as invalid and acc never loads X.
            case (add_exc)
              EXC_NONE: begin
                r_acc <= add_sum;
                if (w_last) r_res_data <= add_sum;
              end
              EXC_OVF: r_res_exc <= EXC_OVF;
              EXC_UNF: r_res_exc <= EXC_UNF;
              default: r_res_exc <= EXC_INV;
            endcase
          end
          if (w_last) begin
            r_state     <= ST_DONE;
            r_res_valid <= 1'b1;
          end else begin
            r_state    <= ST_WAIT_OP;
            r_op_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_state     <= ST_IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_op_ready  <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready  = r_op_ready;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_exc   = r_res_exc;
  assign busy      = r_busy;
  assign count     = r_count;

endmodule

// File: tb/tb_hp_accumulator.sv
module tb_hp_accumulator;
  import hp_pkg::*;

  localparam int LIMIT = 400;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_data;
  logic        op_sub;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic [1:0]  add_exc;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_exc;
  logic        busy;
  logic [7:0]  count;

  int checks;
  int failures;

  logic [15:0] g_ops[$];
  logic        g_sub[$];

  hp_accumulator #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_sub(op_sub),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_exc(add_exc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_exc(res_exc), .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FP16 adder standing in for the team adder.
  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e;
    int  m;
    real v;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 0) v = m * pow2(-24);
    else        v = (1024 + m) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic int rne(input real q);
    real fl;
    real fr;
    int  qi;
    fl = $floor(q);
    fr = q - fl;
    qi = int'(fl);
    if (fr > 0.5 || (fr == 0.5 && (qi % 2) == 1)) qi = qi + 1;
    return qi;
  endfunction

  function automatic logic [17:0] r2h(input real r);
    logic s;
    real  mag;
    int   e;
    int   qi;
    s   = (r < 0.0);
    mag = s ? -r : r;
    if (mag == 0.0) return 18'h0;
    if (mag < pow2(-14)) begin
      qi = rne(mag * pow2(24));
      return {(qi < 1024) ? EXC_UNF : EXC_NONE, s, 15'(qi)};
    end
    e = -14;
    while (mag >= pow2(e + 1)) e++;
    qi = rne(mag / pow2(e - 10));
    if (qi == 2048) begin
      e++;
      qi = 1024;
    end
    if (e > 15) return {EXC_OVF, s, 15'h7C00};
    return {EXC_NONE, s, 5'(e + 15), 10'(qi - 1024)};
  endfunction

  function automatic logic [17:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) return {EXC_INV, 16'h7E00};
    return r2h(h2r(a) + h2r(b));
  endfunction

  always_comb begin
    {add_exc, add_sum} = fp16_add(add_a, add_b);
  end

  // Reference: fold the operand list through the adder, freezing on the first exception.
  task automatic model_job(output logic [15:0] exp_sum, output logic [1:0] exp_exc);
    logic [17:0] r;
    exp_sum = 16'h0000;
    exp_exc = EXC_NONE;
    foreach (g_ops[i]) begin
      if (exp_exc == EXC_NONE) begin
        r = fp16_add(exp_sum, {g_ops[i][15] ^ g_sub[i], g_ops[i][14:0]});
        if (r[17:16] == EXC_NONE) exp_sum = r[15:0];
        else                      exp_exc = r[17:16];
      end
    end
  endtask

  // Drives one job from g_ops/g_sub; returns edges from start to res_valid and operands taken.
  task automatic run_job(input int n, input bit hold, output int cyc, output int taken);
    bit fire;
    int idx;
    idx = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    len   = 8'(n);
    while (1) begin
      if (idx < n) begin
        op_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
        op_data  = g_ops[idx];
        op_sub   = g_sub[idx];
      end else begin
        op_valid = 1'b0;
      end
      fire = op_ready && op_valid;
      @(posedge clk);
      cyc++;
      if (fire) idx++;
      @(negedge clk);
      start = 1'b0;
      if (res_valid || cyc >= LIMIT) break;
    end
    op_valid = 1'b0;
    taken = idx;
    checks++;
    if (cyc >= LIMIT) begin
      failures++;
      $display("FAIL job_timeout: res_valid not seen after %0d cycles (required within %0d)", cyc, LIMIT);
    end
  endtask

  task automatic accept_result();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({op_ready, res_valid, busy} !== 3'b000 || add_a !== 16'h0 || add_b !== 16'h0 ||
        res_data !== 16'h0 || res_exc !== 2'b00 || count !== 8'h0) begin
      failures++;
      $display("FAIL reset_outputs: ready/valid/busy=%b a=%h b=%h data=%h exc=%b count=%0d required all zero",
               {op_ready, res_valid, busy}, add_a, add_b, res_data, res_exc, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sum();
    int cyc, taken;
    g_ops = '{16'h4000, 16'h4200};
    g_sub = '{1'b0, 1'b0};
    run_job(2, 1'b1, cyc, taken);
    checks++;
    if (res_data !== 16'h4500 || res_exc !== EXC_NONE) begin
      failures++;
      $display("FAIL basic_result: got data=%h exc=%b required data=4500 exc=00", res_data, res_exc);
    end
    checks++;
    if (count !== 8'd2) begin
      failures++;
      $display("FAIL basic_count: got %0d required 2", count);
    end
    checks++;
    if (cyc != 5) begin
      failures++;
      $display("FAIL basic_latency: res_valid after %0d cycles required 5", cyc);
    end
    checks++;
    if (op_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_done_status: op_ready=%b busy=%b required 0 1", op_ready, busy);
    end
    accept_result();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_release: res_valid=%b busy=%b required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_subtract();
    int cyc, taken;
    g_ops = '{16'h4200, 16'h4000};
    g_sub = '{1'b0, 1'b1};
    run_job(2, 1'b1, cyc, taken);
    checks++;
    if (res_data !== 16'h3C00 || res_exc !== EXC_NONE) begin
      failures++;
      $display("FAIL subtract_result: got data=%h exc=%b required data=3c00 exc=00", res_data, res_exc);
    end
    checks++;
    if (add_b !== 16'hC000) begin
      failures++;
      $display("FAIL subtract_operand: add_b=%h required c000", add_b);
    end
    accept_result();
  endtask

  task automatic test_overflow_sticky();
    int cyc, taken;
    g_ops = '{16'h7A00, 16'h7B00, 16'h3C00};
    g_sub = '{1'b0, 1'b0, 1'b0};
    run_job(3, 1'b1, cyc, taken);
    checks++;
    if (res_data !== 16'h7A00 || res_exc !== EXC_OVF) begin
      failures++;
      $display("FAIL overflow_result: got data=%h exc=%b required data=7a00 exc=01", res_data, res_exc);
    end
    checks++;
    if (taken != 3 || count !== 8'd3) begin
      failures++;
      $display("FAIL overflow_consumed: handshakes=%0d count=%0d required 3 3", taken, count);
    end
    accept_result();
  endtask

  task automatic test_invalid();
    int cyc, taken;
    g_ops = '{16'h7C00};
    g_sub = '{1'b0};
    run_job(1, 1'b1, cyc, taken);
    checks++;
    if (res_data !== 16'h0000 || res_exc !== EXC_INV) begin
      failures++;
      $display("FAIL invalid_result: got data=%h exc=%b required data=0000 exc=11", res_data, res_exc);
    end
    accept_result();
  endtask

  task automatic test_empty_backpressure();
    int cyc, taken;
    g_ops.delete();
    g_sub.delete();
    run_job(0, 1'b1, cyc, taken);
    checks++;
    if (cyc != 1 || res_data !== 16'h0000 || res_exc !== EXC_NONE) begin
      failures++;
      $display("FAIL empty_result: cycles=%0d data=%h exc=%b required 1 0000 00", cyc, res_data, res_exc);
    end
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || op_ready !== 1'b0 ||
          res_data !== 16'h0 || res_exc !== 2'b00 || count !== 8'h0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: valid=%b busy=%b ready=%b data=%h exc=%b count=%0d required 1 1 0 0000 00 0",
                 i, res_valid, busy, op_ready, res_data, res_exc, count);
      end
    end
    accept_result();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || op_ready !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start: busy=%b op_ready=%b required 0 0", busy, op_ready);
    end
  endtask

  task automatic test_reset_mid_job();
    int cyc, taken;
    @(negedge clk);
    start    = 1'b1;
    len      = 8'd2;
    op_valid = 1'b1;
    op_data  = 16'h4000;
    op_sub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({op_ready, res_valid, busy} !== 3'b000 || add_a !== 16'h0 || add_b !== 16'h0 ||
        res_data !== 16'h0 || res_exc !== 2'b00 || count !== 8'h0) begin
      failures++;
      $display("FAIL reset_mid_job: ready/valid/busy=%b a=%h b=%h data=%h exc=%b count=%0d required all zero",
               {op_ready, res_valid, busy}, add_a, add_b, res_data, res_exc, count);
    end
    @(negedge clk);
    op_valid = 1'b0;
    rst_n    = 1'b1;
    g_ops = '{16'h3C00};
    g_sub = '{1'b0};
    run_job(1, 1'b1, cyc, taken);
    checks++;
    if (res_data !== 16'h3C00 || res_exc !== EXC_NONE) begin
      failures++;
      $display("FAIL after_reset_job: got data=%h exc=%b required 3c00 00", res_data, res_exc);
    end
    accept_result();
  endtask

  task automatic test_random_jobs();
    int          cyc, taken, n;
    logic [15:0] exp_sum, v;
    logic [1:0]  exp_exc;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 8);
      g_ops.delete();
      g_sub.delete();
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 15))
          0:       v = 16'h7C00;
          1:       v = 16'h7BFF;
          2:       v = 16'h8000;
          default: v = {1'($urandom_range(0, 1)), 5'($urandom_range(12, 18)), 10'($urandom)};
        endcase
        g_ops.push_back(v);
        g_sub.push_back(1'($urandom_range(0, 1)));
      end
      model_job(exp_sum, exp_exc);
      run_job(n, 1'b0, cyc, taken);
      checks++;
      if (res_data !== exp_sum || res_exc !== exp_exc || count !== 8'(n) || taken != n) begin
        failures++;
        $display("FAIL random_job[%0d]: data=%h exc=%b count=%0d taken=%0d required %h %b %0d %0d",
                 j, res_data, res_exc, count, taken, exp_sum, exp_exc, n, n);
      end
      accept_result();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    op_valid  = 1'b0;
    op_data   = 16'h0;
    op_sub    = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_basic_sum();
    test_subtract();
    test_overflow_sticky();
    test_invalid();
    test_empty_backpressure();
    test_reset_mid_job();
    test_random_jobs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
